id_decode_pipe: RTL

ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

---
 rtl/id_decode_pipe.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_decode_pipe.sv
// ---------------------------------------------------------------------------
// id_decode_pipe
//   RV32/RV64 instruction decode stage with a single ID/EX pipeline register.
//   Decodes the incoming IF/ID instruction combinationally (immediate, operand
//   use, control), detects load-use hazards against the instruction held in
//   ID/EX, and captures decoded fields plus register-file operands on a
//   transfer (in_valid && in_ready).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   IF/ID handshake
//   in_instr, in_pc     instruction word and its PC
//   rf_raddr1/2         register-file read addresses (combinational, rs1/rs2)
//   rf_rdata1/2         register-file read data (same cycle)
//   flush               kills both the registered and the incoming instruction
//   out_valid/out_ready ID/EX handshake
//   out_*               registered operands, addresses, funct fields, control
//   stall_cnt           saturating count of load-use bubble cycles
// ---------------------------------------------------------------------------
module id_decode_pipe #(
   parameter int XLEN        = 32,
   parameter int ENABLE_M    = 0,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [XLEN-1:0]        in_pc,
   output logic [4:0]             rf_raddr1,
   output logic [4:0]             rf_raddr2,
   input  logic [XLEN-1:0]        rf_rdata1,
   input  logic [XLEN-1:0]        rf_rdata2,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [XLEN-1:0]        out_rs1_data,
   output logic [XLEN-1:0]        out_rs2_data,
   output logic [XLEN-1:0]        out_imm,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [4:0]             out_rd,
   output logic [2:0]             out_funct3,
   output logic [6:0]             out_funct7,
   output logic                   out_reg_write_en,
   output logic                   out_mem_read_en,
   output logic                   out_mem_write_en,
   output logic                   out_branch,
   output logic                   out_jump,
   output logic                   out_jalr,
   output logic                   out_illegal,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic [6:0]             funct7;
   logic [4:0]             rs1, rs2, rd;
   logic signed [31:0]     imm32;
   logic signed [XLEN-1:0] imm_c;
   logic                   use_rs1, use_rs2;
   logic                   we_c, mr_c, mw_c, br_c, jmp_c, jr_c, ill_c;
   logic                   hazard, xfer;

   logic                   vld_p1;
   logic [XLEN-1:0]        pc_p1, rs1_data_p1, rs2_data_p1;
   logic signed [XLEN-1:0] imm_p1;
   logic [4:0]             rs1_p1, rs2_p1, rd_p1;
   logic [2:0]             funct3_p1;
   logic [6:0]             funct7_p1;
   logic                   we_p1, mr_p1, mw_p1, br_p1, jmp_p1, jr_p1, ill_p1;
   logic [STALL_CNT_W-1:0] stall_cnt_p1;

   // ---- stage 0: combinational decode of the IF/ID instruction ----
   assign opcode    = in_instr[6:0];
   assign rd        = in_instr[11:7];
   assign funct3    = in_instr[14:12];
   assign rs1       = in_instr[19:15];
   assign rs2       = in_instr[24:20];
   assign funct7    = in_instr[31:25];
   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   always_comb begin
      imm32   = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      we_c    = 1'b0;
      mr_c    = 1'b0;
      mw_c    = 1'b0;
      br_c    = 1'b0;
      jmp_c   = 1'b0;
      jr_c    = 1'b0;
      ill_c   = 1'b0;
      case (opcode)
         OP_R: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            if (funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                (ENABLE_M != 0 && funct7 == 7'b0000001))
               we_c = 1'b1;
            else
               ill_c = 1'b1;
         end
         OP_IMM: begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            use_rs1 = 1'b1;
            we_c    = 1'b1;
         end
         OP_LOAD: begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            use_rs1 = 1'b1;
            we_c    = 1'b1;
            mr_c    = 1'b1;
         end
         OP_JALR: begin
            // JALR raises both jump and jalr; jalr marks the register-indirect target
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            use_rs1 = 1'b1;
            we_c    = 1'b1;
            jmp_c   = 1'b1;
            jr_c    = 1'b1;
         end
         OP_STORE: begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            mw_c    = 1'b1;
         end
         OP_BRANCH: begin
            imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            br_c    = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm32 = {in_instr[31:12], 12'b0};
            we_c  = 1'b1;
         end
         OP_JAL: begin
            imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            we_c  = 1'b1;
            jmp_c = 1'b1;
         end
         default: ill_c = 1'b1;
      endcase
      if (rd == 5'd0)
         we_c = 1'b0;
   end

   // signed cast sign-extends the 32-bit immediate when XLEN is 64
   assign imm_c = XLEN'(imm32);

   // load in ID/EX whose destination feeds a source actually read here
   assign hazard = vld_p1 && mr_p1 && (rd_p1 != 5'd0) &&
                   ((use_rs1 && rs1 == rd_p1) || (use_rs2 && rs2 == rd_p1));

   assign in_ready = !flush && !hazard && (!vld_p1 || out_ready);
   assign xfer     = in_valid && in_ready;

   // ---- stage 1: ID/EX register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1       <= 1'b0;
         pc_p1        <= '0;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         imm_p1       <= '0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         rd_p1        <= '0;
         funct3_p1    <= '0;
         funct7_p1    <= '0;
         we_p1        <= 1'b0;
         mr_p1        <= 1'b0;
         mw_p1        <= 1'b0;
         br_p1        <= 1'b0;
         jmp_p1       <= 1'b0;
         jr_p1        <= 1'b0;
         ill_p1       <= 1'b0;
         stall_cnt_p1 <= '0;
      end else begin
         if (in_valid && hazard)
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
         if (flush) begin
            vld_p1 <= 1'b0;
         end else if (xfer) begin
            vld_p1      <= 1'b1;
            pc_p1       <= in_pc;
            rs1_data_p1 <= rf_rdata1;
            rs2_data_p1 <= rf_rdata2;
            imm_p1      <= imm_c;
            rs1_p1      <= rs1;
            rs2_p1      <= rs2;
            rd_p1       <= rd;
            funct3_p1   <= funct3;
            funct7_p1   <= funct7;
            we_p1       <= we_c;
            mr_p1       <= mr_c;
            mw_p1       <= mw_c;
            br_p1       <= br_c;
            jmp_p1      <= jmp_c;
            jr_p1       <= jr_c;
            ill_p1      <= ill_c;
         end else if (out_ready) begin
            // consumed with nothing to replace it (covers the load-use bubble)
            vld_p1 <= 1'b0;
         end
      end
   end

   assign out_valid        = vld_p1;
   assign out_pc           = pc_p1;
   assign out_rs1_data     = rs1_data_p1;
   assign out_rs2_data     = rs2_data_p1;
   assign out_imm          = imm_p1;
   assign out_rs1          = rs1_p1;
   assign out_rs2          = rs2_p1;
   assign out_rd           = rd_p1;
   assign out_funct3       = funct3_p1;
   assign out_funct7       = funct7_p1;
   assign out_reg_write_en = we_p1;
   assign out_mem_read_en  = mr_p1;
   assign out_mem_write_en = mw_p1;
   assign out_branch       = br_p1;
   assign out_jump         = jmp_p1;
   assign out_jalr         = jr_p1;
   assign out_illegal      = ill_p1;
   assign stall_cnt        = stall_cnt_p1;

endmodule
